// File: rtl/bg_variance_update_pkg.sv
// Shared types for the Sigma-Delta background/variance update stage.
package md_pkg;
  typedef logic [7:0] pixel_t;

  typedef enum logic {WARMUP = 1'b0, RUN = 1'b1} bgv_state_e;

  typedef struct packed {
    logic   sof;
    pixel_t curr;
    pixel_t prev;
    pixel_t bg;
    pixel_t variance;
  } beat_t;

  // Pixel payload carried down the pipeline once sof has steered the FSM.
  typedef struct packed {
    pixel_t curr;
    pixel_t prev;
    pixel_t bg;
    pixel_t variance;
  } pix_t;
endpackage

// File: rtl/bg_variance_update_if.sv
// Pixel stream bundle: upstream beat in, updated beat out, both valid/ready.
interface bg_variance_update_if;
  import md_pkg::*;

  logic   enable;
  logic   in_valid, in_ready, in_sof;
  pixel_t in_curr, in_prev, in_bg, in_var;
  logic   out_valid, out_ready;
  pixel_t out_curr, out_prev, out_background, out_variance;

  modport master (
    output enable, in_valid, in_sof, in_curr, in_prev, in_bg, in_var, out_ready,
    input  in_ready, out_valid, out_curr, out_prev, out_background, out_variance
  );

  modport slave (
    input  enable, in_valid, in_sof, in_curr, in_prev, in_bg, in_var, out_ready,
    output in_ready, out_valid, out_curr, out_prev, out_background, out_variance
  );
endinterface

// File: rtl/bg_variance_update_step.sv
// One +/-1 step of an 8b value toward a 10b target, clamped to [LO,HI].
module sigma_delta_step
  import md_pkg::*;
#(
  parameter int LO = 0,
  parameter int HI = 255
) (
  input  pixel_t     cur,
  input  logic [9:0] tgt,
  output pixel_t     nxt
);
  logic [9:0] c, s, s_lo, s_hi;

  always_comb begin
    c = {2'b00, cur};
    s = c;
    if (tgt > c)      s = c + 10'd1;
    else if (tgt < c) s = c - 10'd1;
    s_lo = (s > 10'(LO)) ? s : 10'(LO);
    s_hi = (s_lo < 10'(HI)) ? s_lo : 10'(HI);
    nxt  = s_hi[7:0];
  end
endmodule

// File: rtl/bg_variance_update.sv
// Two-stage Sigma-Delta background/variance update with warm-up and periodic variance step.
// Optional BGV_STATS_EN adds per-frame output-beat statistics.
module bg_variance_update
  import md_pkg::*;
#(
  parameter int VAR_MULT   = 2,
  parameter int VAR_MIN    = 2,
  parameter int VAR_MAX    = 250,
  parameter int VAR_PERIOD = 4
) (
  input logic clk,
  input logic rst,
  bg_variance_update_if.slave bus
`ifdef BGV_STATS_EN
  , output logic [19:0] stat_bg_changes
  , output logic [19:0] stat_pixels
`endif
);
  localparam logic [7:0] CNT_LAST = 8'(VAR_PERIOD - 1);

  beat_t      in_b;
  bgv_state_e state_q, state_d;
  logic       started_q, started_d;
  logic [7:0] cnt_q, cnt_d;
  logic       s1_vld_q, s1_vld_d, s2_vld_q, s2_vld_d;
  logic       s1_en_q, s1_en_d, s1_run_q, s1_run_d, s1_upd_q, s1_upd_d;
  pix_t       s1_q, s1_d, s2_q, s2_d;
  logic       s1_rdy, s2_rdy, in_fire, s1_fire;
  pixel_t     bg_step, var_step, d_abs;
  logic [9:0] m;

  always_comb in_b = '{sof: bus.in_sof, curr: bus.in_curr, prev: bus.in_prev,
                       bg: bus.in_bg, variance: bus.in_var};

  always_comb begin
    s2_rdy  = !s2_vld_q || bus.out_ready;
    s1_rdy  = !s1_vld_q || s2_rdy;
    in_fire = bus.in_valid && s1_rdy;
    s1_fire = s1_vld_q && s2_rdy;
  end

  // The first sof after reset opens the warm-up frame; the second one enters RUN.
  always_comb begin
    state_d   = state_q;
    started_d = started_q;
    cnt_d     = cnt_q;
    if (in_fire && in_b.sof) begin
      if (state_q == RUN) cnt_d = (cnt_q == CNT_LAST) ? 8'd0 : cnt_q + 8'd1;
      else if (started_q) state_d = RUN;
      else started_d = 1'b1;
    end
  end

  sigma_delta_step #(.LO(0), .HI(255)) u_bg_step (
    .cur(in_b.bg), .tgt({2'b00, in_b.curr}), .nxt(bg_step)
  );

  always_comb begin
    s1_vld_d = s1_rdy ? bus.in_valid : s1_vld_q;
    s1_d     = s1_q;
    s1_en_d  = s1_en_q;
    s1_run_d = s1_run_q;
    s1_upd_d = s1_upd_q;
    if (in_fire) begin
      s1_d     = '{curr: in_b.curr, prev: in_b.prev, bg: in_b.bg, variance: in_b.variance};
      s1_en_d  = bus.enable;
      s1_run_d = (state_d == RUN);
      s1_upd_d = (cnt_d == 8'd0);
      if (bus.enable) s1_d.bg = (state_d == RUN) ? bg_step : in_b.curr;
    end
  end

  always_comb begin
    d_abs = (s1_q.curr >= s1_q.bg) ? s1_q.curr - s1_q.bg : s1_q.bg - s1_q.curr;
    m     = 10'(VAR_MULT) * {2'b00, d_abs};
  end

  sigma_delta_step #(.LO(VAR_MIN), .HI(VAR_MAX)) u_var_step (
    .cur(s1_q.variance), .tgt(m), .nxt(var_step)
  );

  always_comb begin
    s2_vld_d = s2_rdy ? s1_vld_q : s2_vld_q;
    s2_d     = s2_q;
    if (s1_fire) begin
      s2_d = s1_q;
      if (s1_en_q) begin
        if (!s1_run_q)     s2_d.variance = 8'(VAR_MIN);
        else if (s1_upd_q) s2_d.variance = var_step;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= WARMUP;
      started_q <= 1'b0;
      cnt_q     <= '0;
      s1_vld_q  <= 1'b0;
      s2_vld_q  <= 1'b0;
      s1_en_q   <= 1'b0;
      s1_run_q  <= 1'b0;
      s1_upd_q  <= 1'b0;
      s1_q      <= '0;
      s2_q      <= '0;
    end else begin
      state_q   <= state_d;
      started_q <= started_d;
      cnt_q     <= cnt_d;
      s1_vld_q  <= s1_vld_d;
      s2_vld_q  <= s2_vld_d;
      s1_en_q   <= s1_en_d;
      s1_run_q  <= s1_run_d;
      s1_upd_q  <= s1_upd_d;
      s1_q      <= s1_d;
      s2_q      <= s2_d;
    end
  end

  assign bus.in_ready       = s1_rdy;
  assign bus.out_valid      = s2_vld_q;
  assign bus.out_curr       = s2_q.curr;
  assign bus.out_prev       = s2_q.prev;
  assign bus.out_background = s2_q.bg;
  assign bus.out_variance   = s2_q.variance;

`ifdef BGV_STATS_EN
  logic        s1_sof_q, s1_sof_d, s1_chg_q, s1_chg_d, s2_sof_q, s2_sof_d, s2_chg_q, s2_chg_d;
  logic [19:0] pix_q, pix_d, chg_q, chg_d, snap_pix_q, snap_pix_d, snap_chg_q, snap_chg_d;

  // The sof beat is the first beat of the new frame after the snapshot.
  always_comb begin
    {s1_sof_d, s1_chg_d} = {s1_sof_q, s1_chg_q};
    {s2_sof_d, s2_chg_d} = {s2_sof_q, s2_chg_q};
    pix_d      = pix_q;
    chg_d      = chg_q;
    snap_pix_d = snap_pix_q;
    snap_chg_d = snap_chg_q;
    if (in_fire) {s1_sof_d, s1_chg_d} = {in_b.sof, s1_d.bg != in_b.bg};
    if (s1_fire) {s2_sof_d, s2_chg_d} = {s1_sof_q, s1_chg_q};
    if (s2_vld_q && bus.out_ready) begin
      if (s2_sof_q) begin
        snap_pix_d = pix_q;
        snap_chg_d = chg_q;
        pix_d      = 20'd1;
        chg_d      = {19'd0, s2_chg_q};
      end else begin
        pix_d = pix_q + 20'd1;
        chg_d = chg_q + {19'd0, s2_chg_q};
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      {s1_sof_q, s1_chg_q, s2_sof_q, s2_chg_q} <= '0;
      pix_q      <= '0;
      chg_q      <= '0;
      snap_pix_q <= '0;
      snap_chg_q <= '0;
    end else begin
      {s1_sof_q, s1_chg_q, s2_sof_q, s2_chg_q} <= {s1_sof_d, s1_chg_d, s2_sof_d, s2_chg_d};
      pix_q      <= pix_d;
      chg_q      <= chg_d;
      snap_pix_q <= snap_pix_d;
      snap_chg_q <= snap_chg_d;
    end
  end

  assign stat_pixels     = snap_pix_q;
  assign stat_bg_changes = snap_chg_q;
`endif
endmodule

// File: tb/tb_bg_variance_update.sv
// Bench for bg_variance_update: fixed vectors, stall/reset sequences, random stream vs frame-level model.
module tb_bg_variance_update;
  import md_pkg::*;

  localparam int VMULT = 2, VMIN = 2, VMAX = 250, VPER = 4;

  typedef struct { pixel_t curr, prev, bg, vr; } exp_t;
  typedef struct { logic sof, en; pixel_t curr, prev, bg, vr, ebg, evar; } vec_t;

  logic clk = 1'b0, rst = 1'b1;
  int   checks = 0, failures = 0;
  int   rdy_mode = 0;   // 0: ready, 1: random, 2: stalled
  int   fidx = -1;      // frames seen since reset (-1: none yet)
  exp_t exp_q[$];
  exp_t mon_e;
  int   nout = 0;

  bg_variance_update_if bus();

`ifdef BGV_STATS_EN
  logic [19:0] stat_bg_changes, stat_pixels;
  bg_variance_update dut (.clk(clk), .rst(rst), .bus(bus),
                          .stat_bg_changes(stat_bg_changes), .stat_pixels(stat_pixels));
`else
  bg_variance_update dut (.clk(clk), .rst(rst), .bus(bus));
`endif

  always #5 clk = ~clk;

  initial begin
    bus.out_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      case (rdy_mode)
        0: bus.out_ready = 1'b1;
        1: bus.out_ready = ($urandom_range(0, 3) != 0);
        default: bus.out_ready = 1'b0;
      endcase
    end
  end

  always @(negedge clk) begin
    if (!rst && bus.out_valid && bus.out_ready) begin
      checks++;
      nout++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL out_unexpected beat#%0d got c/p/bg/var=%0d/%0d/%0d/%0d want none",
                 nout, bus.out_curr, bus.out_prev, bus.out_background, bus.out_variance);
      end else begin
        mon_e = exp_q.pop_front();
        if (bus.out_curr !== mon_e.curr || bus.out_prev !== mon_e.prev ||
            bus.out_background !== mon_e.bg || bus.out_variance !== mon_e.vr) begin
          failures++;
          $display("FAIL out_beat#%0d got c/p/bg/var=%0d/%0d/%0d/%0d want %0d/%0d/%0d/%0d",
                   nout, bus.out_curr, bus.out_prev, bus.out_background, bus.out_variance,
                   mon_e.curr, mon_e.prev, mon_e.bg, mon_e.vr);
        end
      end
    end
  end

  task automatic chk(input string name, input int act, input int want);
    checks++;
    if (act != want) begin
      failures++;
      $display("FAIL %s got %0d want %0d", name, act, want);
    end
  endtask

  // Frame-level reference: frame 0 is warm-up, frames 1.. are RUN, variance steps every VPER-th RUN frame.
  function automatic exp_t model(input logic en, input int f, input pixel_t c, p, b, v);
    int ci, bi, vi, bn, vn, m, d;
    exp_t e;
    ci = int'(c); bi = int'(b); vi = int'(v);
    bn = bi; vn = vi;
    if (en) begin
      if (f == 0) begin
        bn = ci; vn = VMIN;
      end else begin
        if (ci > bi) bn = bi + 1;
        else if (ci < bi) bn = bi - 1;
        if (((f - 1) % VPER) == 0) begin
          d = (ci > bn) ? ci - bn : bn - ci;
          m = VMULT * d;
          if (m > vi) vn = vi + 1;
          else if (m < vi) vn = vi - 1;
          if (vn < VMIN) vn = VMIN;
          if (vn > VMAX) vn = VMAX;
        end
      end
    end
    e.curr = c; e.prev = p; e.bg = pixel_t'(bn); e.vr = pixel_t'(vn);
    return e;
  endfunction

  // Called and returns at posedge+1.
  task automatic send(input logic sof, en, input pixel_t c, p, b, v, input exp_t e);
    bit done;
    done = 0;
    bus.in_valid = 1'b1; bus.in_sof = sof; bus.enable = en;
    bus.in_curr = c; bus.in_prev = p; bus.in_bg = b; bus.in_var = v;
    for (int k = 0; k < 200 && !done; k++) begin
      @(negedge clk);
      if (bus.in_ready) begin
        exp_q.push_back(e);
        done = 1;
      end
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0; bus.in_sof = 1'b0;
    if (!done) begin
      checks++; failures++;
      $display("FAIL send_timeout got in_ready=0 want 1 within 200 clk");
    end
  endtask

  task automatic gen_send(input logic sof, input logic en);
    pixel_t c, p, b, v;
    c = pixel_t'($urandom_range(0, 255));
    p = pixel_t'($urandom_range(0, 255));
    v = pixel_t'($urandom_range(0, 255));
    case ($urandom_range(0, 3))
      0: b = c;
      1: b = pixel_t'(int'(c) ^ 1);
      default: b = pixel_t'($urandom_range(0, 255));
    endcase
    if (sof) fidx++;
    send(sof, en, c, p, b, v, model(en, (fidx < 0) ? 0 : fidx, c, p, b, v));
  endtask

  task automatic wait_empty(input string name);
    for (int k = 0; k < 300 && exp_q.size() != 0; k++) @(posedge clk);
    #1;
    chk(name, exp_q.size(), 0);
  endtask

  vec_t tbl[11];
  exp_t te;
  int   seen, blocked, flen, fpos;

  initial begin
    bus.enable = 1'b1; bus.in_valid = 1'b0; bus.in_sof = 1'b0;
    bus.in_curr = '0; bus.in_prev = '0; bus.in_bg = '0; bus.in_var = '0;

    //          sof en  curr prev bg   var  ebg  evar
    tbl[0]  = '{1'b1, 1'b1, 100, 11, 7,   9,   100, 2};
    tbl[1]  = '{1'b1, 1'b1, 120, 12, 100, 30,  101, 31};
    tbl[2]  = '{1'b0, 1'b1, 255, 13, 255, 9,   255, 8};
    tbl[3]  = '{1'b0, 1'b1, 0,   14, 0,   2,   0,   2};
    tbl[4]  = '{1'b0, 1'b1, 0,   15, 200, 250, 199, 250};
    tbl[5]  = '{1'b0, 1'b0, 200, 16, 10,  40,  10,  40};
    tbl[6]  = '{1'b1, 1'b1, 50,  17, 60,  5,   59,  5};
    tbl[7]  = '{1'b0, 1'b1, 0,   18, 0,   0,   0,   0};
    tbl[8]  = '{1'b1, 1'b1, 10,  19, 20,  3,   19,  3};
    tbl[9]  = '{1'b1, 1'b1, 10,  20, 20,  3,   19,  3};
    tbl[10] = '{1'b1, 1'b1, 10,  21, 20,  3,   19,  4};

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset_out_valid", int'(bus.out_valid), 0);
    chk("reset_out_bg", int'(bus.out_background), 0);
    chk("reset_out_var", int'(bus.out_variance), 0);
    chk("reset_out_curr", int'(bus.out_curr), 0);
    chk("reset_in_ready", int'(bus.in_ready), 1);
    @(posedge clk); #1;

    for (int i = 0; i < 11; i++) begin
      te.curr = tbl[i].curr; te.prev = tbl[i].prev; te.bg = tbl[i].ebg; te.vr = tbl[i].evar;
      if (tbl[i].sof) fidx++;
      send(tbl[i].sof, tbl[i].en, tbl[i].curr, tbl[i].prev, tbl[i].bg, tbl[i].vr, te);
    end
    wait_empty("table_drain");

    // Downstream stall while the stream keeps coming.
    fork
      begin
        for (int k = 0; k < 12; k++) gen_send(k == 0, 1'b1);
      end
      begin
        repeat (3) @(posedge clk);
        rdy_mode = 2;
        #2;
        seen = 0;
        for (int k = 0; k < 3 && !seen; k++) begin
          @(negedge clk);
          if (!bus.in_ready) seen = 1;
        end
        chk("stall_in_ready_low_within_2clk", seen, 1);
        blocked = 1;
        repeat (4) begin
          @(negedge clk);
          if (bus.in_ready || !bus.out_valid) blocked = 0;
        end
        chk("stall_held_5clk", blocked, 1);
        rdy_mode = 0;
      end
    join
    wait_empty("stall_drain");

    // Reset with beats in flight.
    rdy_mode = 2;
    @(posedge clk); #1;
    gen_send(1'b1, 1'b1);
    gen_send(1'b0, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    chk("midreset_out_valid", int'(bus.out_valid), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    exp_q.delete();
    fidx = -1;
    rdy_mode = 0;
    @(negedge clk);
    chk("midreset_no_output", int'(bus.out_valid), 0);
    @(posedge clk); #1;
    te.curr = 77; te.prev = 5; te.bg = 77; te.vr = 2;
    fidx = 0;
    send(1'b1, 1'b1, 77, 5, 3, 200, te);
    for (int k = 0; k < 5; k++) gen_send(1'b0, 1'b1);
    wait_empty("midreset_warmup_drain");

    // Random stream with random backpressure, enable and frame lengths.
    rdy_mode = 1;
    flen = 0; fpos = 0;
    for (int k = 0; k < 400; k++) begin
      if (fpos >= flen) begin
        fpos = 0;
        flen = $urandom_range(3, 12);
      end
      gen_send(fpos == 0, $urandom_range(0, 9) != 0);
      fpos++;
      if ($urandom_range(0, 4) == 0) begin
        @(posedge clk); #1;
      end
    end
    rdy_mode = 0;
    wait_empty("random_drain");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    failures++;
    $display("FAIL watchdog got timeout want completion");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
